// File: rtl/ows_tx_engine_if.sv
// Bus/handshake bundle for the 1-wire slave transmit engine.
// A byte transfers on any clock where tx_valid and tx_ready are both high; tx_data must be stable while tx_valid is high.
interface ows_tx_engine_if;
    logic       data_in;
    logic       snd_prsnc;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_abort;
    logic       busy;
    logic       data_out;
    logic       data_out_oe;
    logic [2:0] state_dbg;

    modport master (
        output data_in, snd_prsnc, tx_valid, tx_data,
        input  tx_ready, tx_done, tx_abort, busy, data_out, data_out_oe, state_dbg
    );

    modport slave (
        input  data_in, snd_prsnc, tx_valid, tx_data,
        output tx_ready, tx_done, tx_abort, busy, data_out, data_out_oe, state_dbg
    );
endinterface

// File: rtl/ows_tx_engine.sv
// 1-wire slave transmit engine: presence pulse generation and LSB-first byte
// transmission in master-initiated time slots, with master-reset detection.
module ows_tx_engine #(
    parameter int PRES_WAIT_CYC = 360,
    parameter int PRES_LOW_CYC  = 1440,
    parameter int BIT0_LOW_CYC  = 360,
    parameter int RST_DET_CYC   = 5760
) (
    input  logic            clk,
    input  logic            rst,
    ows_tx_engine_if.slave  bus
);
    localparam int CNT_MAX_A = (PRES_WAIT_CYC > PRES_LOW_CYC) ? PRES_WAIT_CYC : PRES_LOW_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > BIT0_LOW_CYC) ? CNT_MAX_A : BIT0_LOW_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int LOW_W     = $clog2(RST_DET_CYC + 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRES_WAIT    = 3'd1,
        PRES_LOW     = 3'd2,
        PRES_REL     = 3'd3,
        TX_WAIT_FALL = 3'd4,
        TX_HOLD      = 3'd5,
        TX_WAIT_HIGH = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic               oe_q, oe_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               s3_q, s3_d;

    logic fall;
    logic rst_det;
    logic tx_active;

    assign fall      = s3_q & ~s2_q;
    assign rst_det   = (low_cnt_q == LOW_W'(RST_DET_CYC));
    assign tx_active = (state_q == TX_WAIT_FALL) || (state_q == TX_HOLD) ||
                       (state_q == TX_WAIT_HIGH);

    always_comb begin
        s1_d      = bus.data_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        oe_d      = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        // Low-time counter saturates so it cannot wrap past the reset threshold.
        if (s2_q || oe_q) begin
            low_cnt_d = '0;
        end else if (!rst_det) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end else begin
            low_cnt_d = low_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.tx_valid && bus.tx_ready) begin
                    shift_d   = bus.tx_data;
                    bit_cnt_d = 3'd0;
                    state_d   = TX_WAIT_FALL;
                end
            end
            PRES_WAIT: begin
                if (cnt_q == CNT_W'(PRES_WAIT_CYC - 1)) begin
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    state_d = PRES_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRES_LOW: begin
                if (cnt_q == CNT_W'(PRES_LOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = PRES_REL;
                end else begin
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRES_REL: begin
                if (s2_q) state_d = IDLE;
            end
            TX_WAIT_FALL: begin
                if (rst_det) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    // A 0 bit spends one cycle in TX_HOLD before oe rises, giving
                    // the 3-clock latency from the first low sample.
                    cnt_d   = '0;
                    state_d = shift_q[0] ? TX_WAIT_HIGH : TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (cnt_q == CNT_W'(BIT0_LOW_CYC)) begin
                    cnt_d   = '0;
                    state_d = TX_WAIT_HIGH;
                end else begin
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_WAIT_HIGH: begin
                if (rst_det) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (s2_q) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = TX_WAIT_FALL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A presence request preempts whatever the engine was doing.
        if (bus.snd_prsnc) begin
            state_d = PRES_WAIT;
            cnt_d   = '0;
            oe_d    = 1'b0;
            done_d  = 1'b0;
            abort_d = tx_active;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            low_cnt_q <= '0;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s3_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            low_cnt_q <= low_cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
        end
    end

    assign bus.tx_ready    = (state_q == IDLE) && !bus.snd_prsnc;
    assign bus.tx_done     = done_q;
    assign bus.tx_abort    = abort_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.data_out    = 1'b0;
    assign bus.data_out_oe = oe_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_ows_tx_engine.sv
// Directed bench for ows_tx_engine: presence timing, byte slots from a vector
// table, master-reset abort, presence preemption and synchronous reset.
module tb_ows_tx_engine;
    logic clk;
    logic rst;
    logic master_low;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    ows_tx_engine_if bus ();

    ows_tx_engine #(
        .PRES_WAIT_CYC (4),
        .PRES_LOW_CYC  (8),
        .BIT0_LOW_CYC  (5),
        .RST_DET_CYC   (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Open-drain bus: low if the master or the engine pulls it down.
    assign bus.data_in = ~(master_low | bus.data_out_oe);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_abort) abort_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] drive_mask;
    } vec_t;

    vec_t vecs [4];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        else
            n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic rdy);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        #1 rdy = bus.tx_ready;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic do_slot(output int lat, output int width);
        lat   = -1;
        width = 0;
        @(negedge clk);
        master_low = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (c == 1) master_low = 1'b0;
            if (bus.data_out_oe) begin
                if (lat < 0) lat = c;
                width++;
            end
        end
    endtask

    task automatic run_presence(input bit with_valid, output int pre_low, output int high_w,
                                output int idle_at, output logic abort0, output logic rdy_pre);
        bit seen_high;
        @(negedge clk);
        bus.snd_prsnc = 1'b1;
        if (with_valid) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'h00;
        end
        #1 rdy_pre = bus.tx_ready;
        @(posedge clk); #1;
        bus.snd_prsnc = 1'b0;
        bus.tx_valid  = 1'b0;
        pre_low   = 0;
        high_w    = 0;
        idle_at   = -1;
        seen_high = 1'b0;
        abort0    = bus.tx_abort;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (bus.data_out_oe) begin
                seen_high = 1'b1;
                high_w++;
            end else if (!seen_high) begin
                pre_low++;
            end
            if (!bus.busy && idle_at < 0) idle_at = c;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, width, pre_low, high_w, idle_at, d0, a0, first_abort, abort_cycles;
        logic rdy, abort0;

        vecs[0] = '{data: 8'hA5, drive_mask: 8'h5A};
        vecs[1] = '{data: 8'hFF, drive_mask: 8'h00};
        vecs[2] = '{data: 8'h00, drive_mask: 8'hFF};
        vecs[3] = '{data: 8'h3C, drive_mask: 8'hC3};

        master_low    = 1'b0;
        bus.snd_prsnc = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_oe",       32'(bus.data_out_oe), 32'd0);
        check("reset_data_out", 32'(bus.data_out),    32'd0);
        check("reset_busy",     32'(bus.busy),        32'd0);
        check("reset_ready",    32'(bus.tx_ready),    32'd1);
        check("reset_done",     32'(bus.tx_done),     32'd0);
        check("reset_abort",    32'(bus.tx_abort),    32'd0);

        // Presence on an idle bus.
        run_presence(1'b0, pre_low, high_w, idle_at, abort0, rdy);
        check("pres_wait_len", 32'(pre_low), 32'd4);
        check("pres_low_len",  32'(high_w),  32'd8);
        check("pres_idle_at",  32'(idle_at), 32'd15);
        check("pres_no_abort", 32'(abort0),  32'd0);

        // Byte vectors: expected per-slot oe width is 5 for a 0 bit, 0 for a 1 bit.
        foreach (vecs[v]) begin
            for (int s = 0; s < 8; s++) exp_q.push_back(vecs[v].drive_mask[s] ? 32'd5 : 32'd0);
            d0 = done_cnt;
            send_byte(vecs[v].data, rdy);
            check("byte_ready_pre", 32'(rdy),      32'd1);
            check("byte_busy",      32'(bus.busy), 32'd1);
            for (int s = 0; s < 8; s++) begin
                logic [31:0] exp_w;
                do_slot(lat, width);
                exp_w = exp_q.pop_front();
                check($sformatf("slot_width_v%0d_b%0d", v, s), 32'(width), exp_w);
                if (exp_w != 0)
                    check($sformatf("slot_latency_v%0d_b%0d", v, s), 32'(lat), 32'd3);
                if (s == 3) begin
                    check("byte_ready_mid",  32'(bus.tx_ready), 32'd0);
                    check("byte_no_done_mid", 32'(done_cnt - d0), 32'd0);
                end
            end
            repeat (2) @(posedge clk); #1;
            check("byte_done_once", 32'(done_cnt - d0), 32'd1);
            check("byte_idle_busy", 32'(bus.busy),      32'd0);
            check("byte_idle_ready", 32'(bus.tx_ready), 32'd1);
        end

        // Presence and tx_valid together: presence wins.
        d0 = done_cnt;
        a0 = abort_cnt;
        run_presence(1'b1, pre_low, high_w, idle_at, abort0, rdy);
        check("both_ready",     32'(rdy),     32'd0);
        check("both_pres_wait", 32'(pre_low), 32'd4);
        check("both_pres_low",  32'(high_w),  32'd8);
        check("both_idle_at",   32'(idle_at), 32'd15);
        check("both_no_events", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);

        // Master reset detected mid-byte.
        d0 = done_cnt;
        a0 = abort_cnt;
        send_byte(8'hFF, rdy);
        for (int s = 0; s < 3; s++) do_slot(lat, width);
        first_abort  = -1;
        abort_cycles = 0;
        @(negedge clk);
        master_low = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (c == 24) master_low = 1'b0;
            if (bus.tx_abort) begin
                if (first_abort < 0) first_abort = c;
                abort_cycles++;
            end
        end
        check("rstdet_abort_at",    32'(first_abort),     32'd22);
        check("rstdet_abort_width", 32'(abort_cycles),    32'd1);
        check("rstdet_no_done",     32'(done_cnt - d0),   32'd0);
        check("rstdet_idle",        32'(bus.busy),        32'd0);
        check("rstdet_ready",       32'(bus.tx_ready),    32'd1);

        // Presence request while holding a 0 bit low.
        a0 = abort_cnt;
        send_byte(8'hA5, rdy);
        do_slot(lat, width);
        @(negedge clk);
        master_low = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) master_low = 1'b0;
        end
        check("hold_oe_before", 32'(bus.data_out_oe), 32'd1);
        run_presence(1'b0, pre_low, high_w, idle_at, abort0, rdy);
        check("hold_abort_now",  32'(abort0),            32'd1);
        check("hold_abort_once", 32'(abort_cnt - a0),    32'd1);
        check("hold_pres_wait",  32'(pre_low),           32'd4);
        check("hold_pres_low",   32'(high_w),            32'd8);
        check("hold_idle_at",    32'(idle_at),           32'd15);

        // Synchronous reset in the middle of the presence pulse.
        a0 = abort_cnt;
        @(negedge clk);
        bus.snd_prsnc = 1'b1;
        @(posedge clk); #1;
        bus.snd_prsnc = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("rstpres_oe_before", 32'(bus.data_out_oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstpres_oe",    32'(bus.data_out_oe), 32'd0);
        check("rstpres_busy",  32'(bus.busy),        32'd0);
        check("rstpres_ready", 32'(bus.tx_ready),    32'd1);
        check("rstpres_abort", 32'(bus.tx_abort),    32'd0);
        check("rstpres_done",  32'(bus.tx_done),     32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rstpres_no_abort", 32'(abort_cnt - a0), 32'd0);
        check("rstpres_idle",     32'(bus.busy),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ows_tx_engine.md
OWS_TX_ENGINE -- requirements
Module: ows_tx_engine

Interface
REQ-001 SHALL have parameter PRES_WAIT_CYC, default 360, clocks from snd_prsnc to presence-pulse start.
REQ-002 SHALL have parameter PRES_LOW_CYC, default 1440, clocks the presence pulse holds the bus low.
REQ-003 SHALL have parameter BIT0_LOW_CYC, default 360, clocks the bus is held low for a transmitted 0 bit.
REQ-004 SHALL have parameter RST_DET_CYC, default 5760, clocks of continuous bus-low, not self-driven, that count as a master reset.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 data_in  input  1  raw asynchronous 1-wire bus level.
REQ-008 snd_prsnc  input  1  single-cycle request to issue a presence pulse.
REQ-009 tx_valid  input  1  byte offered for transmission.
REQ-010 tx_data  input  8  byte to transmit, LSB first.
REQ-011 tx_ready  output  1  engine accepts a byte this cycle.
REQ-012 tx_done  output  1  single-cycle pulse: 8th bit slot complete.
REQ-013 tx_abort  output  1  single-cycle pulse: transfer aborted by master reset or snd_prsnc.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 data_out  output  1  constant 0; the bus is only ever pulled low.
REQ-016 data_out_oe  output  1  registered; 1 pulls the bus low.

Function
REQ-017 data_in SHALL pass a 2-FF synchronizer (s1, s2) plus history flop s3; fall = s3 & ~s2; rise = ~s3 & s2.
REQ-018 States: IDLE, PRES_WAIT, PRES_LOW, PRES_REL, TX_WAIT_FALL, TX_HOLD, TX_WAIT_HIGH.
REQ-019 tx_ready SHALL be 1 only in IDLE and only when snd_prsnc is 0 in that cycle.
REQ-020 tx_valid & tx_ready SHALL load tx_data into an 8-bit shift register, clear the 3-bit bit counter, and move to TX_WAIT_FALL.
REQ-021 snd_prsnc in any state SHALL move to PRES_WAIT next cycle, reload the cycle counter, and deassert oe; if a byte is loaded and not yet done, tx_abort pulses in that same next cycle.
REQ-022 snd_prsnc and tx_valid together in IDLE: presence wins, byte not accepted.
REQ-023 PRES_WAIT SHALL last PRES_WAIT_CYC clocks, then PRES_LOW.
REQ-024 In PRES_LOW, oe = 1 for exactly PRES_LOW_CYC clocks; then PRES_REL with oe = 0.
REQ-025 PRES_REL SHALL wait for s2 = 1, then go to IDLE.
REQ-026 TX_WAIT_FALL: on fall, if shift[0] = 0, go to TX_HOLD with oe = 1 from the next clock; if shift[0] = 1, go to TX_WAIT_HIGH without driving.
REQ-027 oe SHALL rise exactly 3 clocks after the first clk edge that samples data_in low; any shorter latency is a defect.
REQ-028 TX_HOLD SHALL keep oe = 1 for exactly BIT0_LOW_CYC clocks, then deassert oe and go to TX_WAIT_HIGH.
REQ-029 TX_WAIT_HIGH on s2 = 1: shift right by one and increment the bit counter; after bit 7, pulse tx_done and go to IDLE, otherwise go to TX_WAIT_FALL.
REQ-030 The bit counter SHALL wrap 7->0 only via the tx_done path.
REQ-031 A low-time counter SHALL count clocks with s2 = 0 and oe = 0, clearing on s2 = 1 or oe = 1.
REQ-032 When the low-time counter reaches RST_DET_CYC during TX_WAIT_FALL or TX_WAIT_HIGH, the engine SHALL pulse tx_abort and go to IDLE.
REQ-033 During a presence sequence, the reset-detect condition SHALL be ignored.
REQ-034 Cycle counters SHALL be wide enough for max(parameter), with no wrap before terminal count.

Reset
REQ-035 With rst = 1 at a clock edge, the next state SHALL be: IDLE, oe = 0, data_out = 0, tx_done = 0, tx_abort = 0, busy = 0, tx_ready = 1, shift = 0, counters = 0, s1/s2/s3 = 1.
REQ-036 rst SHALL override every input, including mid-presence and mid-byte, with no abort pulse generated.

Verification (PRES_WAIT_CYC=4, PRES_LOW_CYC=8, BIT0_LOW_CYC=5, RST_DET_CYC=20)
REQ-037 snd_prsnc pulse, bus idle high -> oe = 0 for 4 clocks, then oe = 1 for exactly 8 clocks, busy until s2 = 1, then IDLE.
REQ-038 tx_data = 8'hA5 with 8 master slots (2-clock low, then master release) -> driven-low slots are bits 1, 3, 4, 6, each oe = 5 clocks starting 3 clocks after the fall; tx_done pulses once after slot 8.
REQ-039 tx_data = 8'hFF -> oe never asserts; tx_done after 8 slots; tx_ready 0 until then.
REQ-040 Mid-byte (after 3 slots) master holds bus low 25 clocks -> tx_abort pulses at low count 20; IDLE; tx_done never pulses.
REQ-041 snd_prsnc during TX_HOLD -> oe drops next clock, tx_abort pulses, presence sequence per REQ-037 follows.
REQ-042 rst asserted during PRES_LOW -> oe = 0 next clock, all outputs at reset values, tx_abort stays 0.
